// File: rtl/shift_pkg.sv
// rtl/shift_pkg.sv - shared widths, shift op codes and arbiter state type
package shift_pkg;
  localparam int DATA_W  = 32;
  localparam int SHAMT_W = 5;

  typedef logic [1:0] shift_op_t;

  localparam shift_op_t SHIFT_SLL = 2'b00;
  localparam shift_op_t SHIFT_SRL = 2'b01;
  localparam shift_op_t SHIFT_SRA = 2'b10;

  typedef enum logic {
    ST_EMPTY = 1'b0,
    ST_FULL  = 1'b1
  } arb_state_e;
endpackage

// File: rtl/shifter_arbiter_if.sv
// rtl/shifter_arbiter_if.sv - two shift requesters plus the result slot handshake
interface shifter_arbiter_if;
  import shift_pkg::*;

  logic               req0_valid;
  logic               req0_ready;
  logic [DATA_W-1:0]  req0_data;
  logic [SHAMT_W-1:0] req0_shamt;
  shift_op_t          req0_op;

  logic               req1_valid;
  logic               req1_ready;
  logic [DATA_W-1:0]  req1_data;
  logic [SHAMT_W-1:0] req1_shamt;
  shift_op_t          req1_op;

  logic               out_valid;
  logic               out_ready;
  logic [DATA_W-1:0]  out_data;
  logic               out_tag;

  modport slave (
    input  req0_valid, req0_data, req0_shamt, req0_op,
    output req0_ready,
    input  req1_valid, req1_data, req1_shamt, req1_op,
    output req1_ready,
    output out_valid, out_data, out_tag,
    input  out_ready
  );

  modport master (
    output req0_valid, req0_data, req0_shamt, req0_op,
    input  req0_ready,
    output req1_valid, req1_data, req1_shamt, req1_op,
    input  req1_ready,
    input  out_valid, out_data, out_tag,
    output out_ready
  );
endinterface

// File: rtl/shifter_arbiter_barrel_shifter.sv
// rtl/shifter_arbiter_barrel_shifter.sv - combinational 32-bit log shifter (SLL/SRL/SRA)
module barrel_shifter
  import shift_pkg::*;
(
  input  logic [DATA_W-1:0]  i_data,
  input  logic [SHAMT_W-1:0] i_shamt,
  input  shift_op_t          i_op,
  output logic [DATA_W-1:0]  o_data
);
  logic              w_right;
  logic              w_fill;
  logic [DATA_W-1:0] w_st16;
  logic [DATA_W-1:0] w_st8;
  logic [DATA_W-1:0] w_st4;
  logic [DATA_W-1:0] w_st2;

  // Reserved op 11 falls into the left-shift path.
  assign w_right = (i_op == SHIFT_SRL) || (i_op == SHIFT_SRA);
  assign w_fill  = (i_op == SHIFT_SRA) && i_data[DATA_W-1];

  assign w_st16 = !i_shamt[4] ? i_data :
                  (w_right ? {{16{w_fill}}, i_data[31:16]} : {i_data[15:0], 16'b0});
  assign w_st8  = !i_shamt[3] ? w_st16 :
                  (w_right ? {{8{w_fill}}, w_st16[31:8]} : {w_st16[23:0], 8'b0});
  assign w_st4  = !i_shamt[2] ? w_st8 :
                  (w_right ? {{4{w_fill}}, w_st8[31:4]} : {w_st8[27:0], 4'b0});
  assign w_st2  = !i_shamt[1] ? w_st4 :
                  (w_right ? {{2{w_fill}}, w_st4[31:2]} : {w_st4[29:0], 2'b0});
  assign o_data = !i_shamt[0] ? w_st2 :
                  (w_right ? {w_fill, w_st2[31:1]} : {w_st2[30:0], 1'b0});
endmodule

// File: rtl/shifter_arbiter.sv
// rtl/shifter_arbiter.sv - round-robin share of one barrel shifter between two requesters
module shifter_arbiter
  import shift_pkg::*;
(
  input  logic              clock,
  input  logic              reset_n,
  shifter_arbiter_if.slave  bus
);
  arb_state_e         r_state;
  arb_state_e         w_state_nxt;
  logic               r_rr_ptr;
  logic [DATA_W-1:0]  r_out_data;
  logic               r_out_tag;

  logic               w_can_accept;
  logic               w_grant_vld;
  logic               w_grant_idx;
  logic               w_xfer;
  logic [DATA_W-1:0]  w_sel_data;
  logic [SHAMT_W-1:0] w_sel_shamt;
  shift_op_t          w_sel_op;
  logic [DATA_W-1:0]  w_shift_res;

  assign bus.out_valid = (r_state == ST_FULL);
  assign bus.out_data  = r_out_data;
  assign bus.out_tag   = r_out_tag;

  assign w_can_accept = !bus.out_valid || bus.out_ready;
  assign w_grant_vld  = bus.req0_valid || bus.req1_valid;
  assign w_grant_idx  = (bus.req0_valid && bus.req1_valid) ? r_rr_ptr : bus.req1_valid;
  assign w_xfer       = w_grant_vld && w_can_accept;

  // reset_n gates the readies directly so they drop without waiting for an edge.
  assign bus.req0_ready = reset_n && w_xfer && !w_grant_idx;
  assign bus.req1_ready = reset_n && w_xfer &&  w_grant_idx;

  assign w_sel_data  = w_grant_idx ? bus.req1_data  : bus.req0_data;
  assign w_sel_shamt = w_grant_idx ? bus.req1_shamt : bus.req0_shamt;
  assign w_sel_op    = w_grant_idx ? bus.req1_op    : bus.req0_op;

  barrel_shifter u_shifter (
    .i_data  (w_sel_data),
    .i_shamt (w_sel_shamt),
    .i_op    (w_sel_op),
    .o_data  (w_shift_res)
  );

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      r_state <= ST_EMPTY;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      ST_EMPTY: if (w_xfer) w_state_nxt = ST_FULL;
      ST_FULL:  if (bus.out_ready && !w_xfer) w_state_nxt = ST_EMPTY;
      default:  w_state_nxt = ST_EMPTY;
    endcase
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      r_out_data <= '0;
      r_out_tag  <= 1'b0;
      r_rr_ptr   <= 1'b0;
    end else if (w_xfer) begin
      r_out_data <= w_shift_res;
      r_out_tag  <= w_grant_idx;
      r_rr_ptr   <= ~w_grant_idx;
    end
  end
endmodule

// File: tb/tb_shifter_arbiter.sv
// tb/tb_shifter_arbiter.sv - randomized and directed bench for shifter_arbiter
module tb_shifter_arbiter;
  import shift_pkg::*;

  logic clock   = 1'b0;
  logic reset_n = 1'b1;
  int   n_checks = 0;
  int   n_fail   = 0;

  shifter_arbiter_if bus();

  shifter_arbiter dut (
    .clock   (clock),
    .reset_n (reset_n),
    .bus     (bus)
  );

  always #5 clock = ~clock;

  logic [32:0] exp_q[$];
  logic        m_ptr;
  int          missed0, missed1;
  logic        got_r0, got_r1;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%08h exp=%08h at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic logic [31:0] ref_shift(input logic [31:0] d, input int s, input logic [1:0] o);
    logic signed [31:0] sd;
    sd = d;
    case (o)
      2'b01:   return d >> s;
      2'b10:   return 32'(sd >>> s);
      default: return d << s;
    endcase
  endfunction

  task automatic model_clear();
    exp_q.delete();
    m_ptr   = 1'b0;
    missed0 = 0;
    missed1 = 0;
  endtask

  task automatic do_reset();
    bus.req0_valid = 1'b1; bus.req1_valid = 1'b1; bus.out_ready = 1'b1;
    reset_n = 1'b0;
    #1;
    chk("rst_out_valid", 32'(bus.out_valid), 0);
    chk("rst_out_data", bus.out_data, 0);
    chk("rst_out_tag", 32'(bus.out_tag), 0);
    chk("rst_ready0", 32'(bus.req0_ready), 0);
    chk("rst_ready1", 32'(bus.req1_ready), 0);
    @(posedge clock); #1;
    reset_n = 1'b1;
    bus.req0_valid = 1'b0; bus.req1_valid = 1'b0;
    model_clear();
  endtask

  // One clock: drive, check against the scoreboard at negedge, advance the model at posedge.
  task automatic run_cycle(input logic v0, input logic [31:0] d0, input logic [4:0] s0, input logic [1:0] o0,
                           input logic v1, input logic [31:0] d1, input logic [4:0] s1, input logic [1:0] o1,
                           input logic ordy);
    logic can, gv, win;
    bus.req0_valid = v0; bus.req0_data = d0; bus.req0_shamt = s0; bus.req0_op = o0;
    bus.req1_valid = v1; bus.req1_data = d1; bus.req1_shamt = s1; bus.req1_op = o1;
    bus.out_ready  = ordy;
    @(negedge clock);
    can = (exp_q.size() == 0) || ordy;
    gv  = v0 || v1;
    win = (v0 && v1) ? m_ptr : v1;
    chk("ready0", 32'(bus.req0_ready), 32'(gv && can && !win));
    chk("ready1", 32'(bus.req1_ready), 32'(gv && can && win));
    chk("out_valid", 32'(bus.out_valid), 32'(exp_q.size() != 0));
    if (exp_q.size() != 0) begin
      chk("out_data", bus.out_data, exp_q[0][31:0]);
      chk("out_tag", 32'(bus.out_tag), 32'(exp_q[0][32]));
    end
    got_r0 = bus.req0_ready;
    got_r1 = bus.req1_ready;
    @(posedge clock);
    if (exp_q.size() != 0 && ordy) void'(exp_q.pop_front());
    if (gv && can) begin
      exp_q.push_back({win, win ? ref_shift(d1, int'(s1), o1) : ref_shift(d0, int'(s0), o0)});
      m_ptr = !win;
      if (!win) begin
        missed0 = 0;
        if (v1) begin missed1++; chk("fair1", 32'(missed1 <= 2), 1); end
      end else begin
        missed1 = 0;
        if (v0) begin missed0++; chk("fair0", 32'(missed0 <= 2), 1); end
      end
    end
    #1;
  endtask

  logic [31:0] bd_data [4] = '{32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'h7FFF_FFFF, 32'h1234_5678};
  logic [4:0]  bd_sh   [4] = '{5'd0, 5'd31, 5'd31, 5'd8};
  logic [1:0]  bd_op   [4] = '{SHIFT_SRL, SHIFT_SRL, SHIFT_SRA, 2'b11};
  logic [31:0] bd_exp  [4] = '{32'hFFFF_FFFF, 32'h0000_0001, 32'h0000_0000, 32'h3456_7800};

  logic        cv [2];
  logic [31:0] cd [2];
  logic [4:0]  cs [2];
  logic [1:0]  co [2];
  logic [31:0] held;

  initial begin
    bus.req0_valid = 0; bus.req0_data = 0; bus.req0_shamt = 0; bus.req0_op = 0;
    bus.req1_valid = 0; bus.req1_data = 0; bus.req1_shamt = 0; bus.req1_op = 0;
    bus.out_ready  = 0;
    #2;
    do_reset();

    run_cycle(1, 32'h8000_00F0, 5'd4, SHIFT_SRA, 0, 0, 0, 0, 1);
    chk("single_ready0", 32'(got_r0), 1);
    chk("single_valid", 32'(bus.out_valid), 1);
    chk("single_data", bus.out_data, 32'hF800_000F);
    chk("single_tag", 32'(bus.out_tag), 0);

    do_reset();
    for (int i = 0; i < 4; i++) begin
      run_cycle(1, 32'(i), 0, SHIFT_SLL, 1, 32'(i + 16), 0, SHIFT_SLL, 1);
      chk("cont_grant1", 32'(got_r1), 32'(i % 2));
      chk("cont_grant0", 32'(got_r0), 32'(1 - i % 2));
      chk("cont_valid", 32'(bus.out_valid), 1);
      chk("cont_tag", 32'(bus.out_tag), 32'(i % 2));
    end

    run_cycle(1, 32'hA5A5_0000, 5'd3, SHIFT_SRL, 0, 0, 0, 0, 1);
    held = bus.out_data;
    for (int i = 0; i < 3; i++) begin
      run_cycle(0, 0, 0, 0, 1, 32'h0000_0001, 5'd31, SHIFT_SLL, 0);
      chk("bp_ready1", 32'(got_r1), 0);
      chk("bp_stable", bus.out_data, held);
    end
    run_cycle(0, 0, 0, 0, 1, 32'h0000_0001, 5'd31, SHIFT_SLL, 1);
    chk("bp_release_ready1", 32'(got_r1), 1);
    chk("bp_data", bus.out_data, 32'h8000_0000);
    chk("bp_tag", 32'(bus.out_tag), 1);

    for (int i = 0; i < 4; i++) begin
      run_cycle(1, bd_data[i], bd_sh[i], bd_op[i], 0, 0, 0, 0, 1);
      chk("boundary", bus.out_data, bd_exp[i]);
    end

    // Reset arriving while the slot is stalled.
    run_cycle(1, 32'h0000_00FF, 5'd1, SHIFT_SLL, 0, 0, 0, 0, 0);
    bus.req0_valid = 0; bus.req1_valid = 1; bus.out_ready = 0;
    #2;
    reset_n = 1'b0;
    #1;
    chk("rst_stall_valid", 32'(bus.out_valid), 0);
    chk("rst_stall_ready1", 32'(bus.req1_ready), 0);
    @(posedge clock); #1;
    reset_n = 1'b1;
    model_clear();
    chk("rst_stall_ptr", 32'(dut.r_rr_ptr), 0);
    run_cycle(0, 0, 0, 0, 1, 32'h0000_0010, 5'd2, SHIFT_SRL, 1);
    chk("rst_stall_grant1", 32'(got_r1), 1);
    chk("rst_stall_tag", 32'(bus.out_tag), 1);
    chk("rst_stall_data", bus.out_data, 32'h0000_0004);

    got_r0 = 0; got_r1 = 0;
    for (int n = 0; n < 2; n++) cv[n] = 0;
    for (int c = 0; c < 10000; c++) begin
      for (int n = 0; n < 2; n++) begin
        if (!(cv[n] && !(n == 0 ? got_r0 : got_r1))) begin
          cv[n] = ($urandom_range(0, 3) != 0);
          cd[n] = $urandom;
          cs[n] = 5'($urandom_range(0, 31));
          co[n] = 2'($urandom_range(0, 3));
        end
      end
      run_cycle(cv[0], cd[0], cs[0], co[0], cv[1], cd[1], cs[1], co[1], ($urandom_range(0, 3) != 0));
    end

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end
endmodule
